mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_SIZE, 16, address width and memory word width in bits.
REQ-002 Parameter LINE_WORDS, 4, words per cache line; line width is LW = WORD_SIZE*LINE_WORDS.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 i_req  input  1  I-cache line-fill request (read only), level, held until i_ready.
REQ-006 i_addr  input  WORD_SIZE  I-cache line address.
REQ-007 i_ready  output  1  one-cycle pulse: I access complete, i_rdata valid.
REQ-008 i_rdata  output  LW  line returned to I-cache.
REQ-009 d_req  input  1  D-cache request, level, held until d_ready.
REQ-010 d_we  input  1  1 = line writeback, 0 = line fill.
REQ-011 d_addr  input  WORD_SIZE  D-cache line address.
REQ-012 d_wdata  input  LW  writeback line.
REQ-013 d_ready  output  1  one-cycle pulse: D access complete, d_rdata valid on reads.
REQ-014 d_rdata  output  LW  line returned to D-cache.
REQ-015 mem_req, mem_we  output  1 each  memory port request / write select.
REQ-016 mem_addr  output  WORD_SIZE; mem_wdata  output  LW  memory port address / write line.
REQ-017 mem_ack  input  1  one-cycle pulse from memory: access complete, mem_rdata valid.
REQ-018 mem_rdata  input  LW  memory read line.
REQ-019 i_grant_cnt, d_grant_cnt  output  16 each  saturating grant counters.

Function
REQ-020 FSM states IDLE, GRANT_I, GRANT_D, DONE; exactly one state active.
REQ-021 IDLE: if only i_req -> GRANT_I; if only d_req -> GRANT_D; if both -> grant requester not granted last (last_grant register); neither -> stay IDLE.
REQ-022 On grant edge, latch address, we (0 for I) and wdata; later changes on requester inputs are ignored until DONE.
REQ-023 mem_req, mem_we, mem_addr, mem_wdata are registered and held constant throughout GRANT_I/GRANT_D; mem_req=0 in IDLE and DONE.
REQ-024 Latency: request seen in IDLE at cycle N -> mem_req high at cycle N+1.
REQ-025 GRANT_x with mem_ack=1 at cycle M -> DONE at M+1 with x_ready=1 and x_rdata=mem_rdata captured at M; IDLE at M+2.
REQ-026 x_rdata holds its value until next completion for that requester; on writes d_rdata is unchanged.
REQ-027 DONE never samples requests; requester deasserts req on the edge where its ready is high, giving one bubble cycle.
REQ-028 mem_ack in IDLE or DONE is ignored; no ready pulse, no state change.
REQ-029 i_ready and d_ready never high in the same cycle; at most one pulse per grant.
REQ-030 last_grant updates at grant; counter of winner increments at grant, saturating at 16'hFFFF.
REQ-031 Request deasserted during GRANT_x (protocol violation) does not abort the access; access completes normally.

Reset
REQ-032 reset=1 at an edge: state=IDLE, last_grant=I (D wins first tie), mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, i_ready=d_ready=0, i_rdata=d_rdata=0, both counters=0.
REQ-033 Reset mid-access drops the pending access without a ready pulse; a mem_ack arriving after reset is ignored per REQ-028.

Structure
REQ-034 WORD_SIZE, LINE_WORDS and FSM state encodings live in the shared opcodes/constants include; state width is 2 bits.
REQ-035 One sub-module, sat_counter16 (enable, synchronous reset, saturate), instantiated twice; arbitration and FSM stay in mem_arbiter.

Verification
REQ-036 i_req=1, i_addr=16'h0040 alone; mem_ack 3 cycles after mem_req -> mem_addr=16'h0040, mem_we=0, i_ready one cycle after ack, i_rdata=mem_rdata, i_grant_cnt=1.
REQ-037 i_req and d_req (d_we=1, d_addr=16'h0100) rise same cycle after reset -> D granted first with mem_we=1 and mem_wdata=d_wdata; I granted in the first IDLE after DONE.
REQ-038 Both held continuously for 6 accesses -> grants alternate D,I,D,I,D,I; d_grant_cnt=i_grant_cnt=3.
REQ-039 reset asserted during GRANT_D, mem_ack pulses 2 cycles later -> no d_ready, mem_req=0, state IDLE, counters 0.
REQ-040 Spurious mem_ack in IDLE; i_addr changed mid-grant -> no ready pulses, mem_addr keeps latched value.
REQ-041 Preload d_grant_cnt to 16'hFFFE via 2 more grants than remaining -> counter holds 16'hFFFF.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and encodings for the I/D memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned WORD_SIZE  = 16;
  localparam int unsigned LINE_WORDS = 4;

  // Arbiter FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Which requester won the most recent grant.
  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } last_t;

endpackage

// File: rtl/mem_arbiter_sat_counter16.sv
// 16-bit event counter with enable and synchronous reset; sticks at all-ones.
module sat_counter16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] count
);

  // Count enabled cycles, holding once the maximum is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter in front of a single line-wide
// memory port. Alternates on contention, one access in flight at a time.
module mem_arbiter #(
  parameter int unsigned WORD_SIZE  = mem_arbiter_pkg::WORD_SIZE,
  parameter int unsigned LINE_WORDS = mem_arbiter_pkg::LINE_WORDS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_req,
  input  logic [WORD_SIZE-1:0]            i_addr,
  output logic                            i_ready,
  output logic [WORD_SIZE*LINE_WORDS-1:0] i_rdata,
  input  logic                            d_req,
  input  logic                            d_we,
  input  logic [WORD_SIZE-1:0]            d_addr,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] d_wdata,
  output logic                            d_ready,
  output logic [WORD_SIZE*LINE_WORDS-1:0] d_rdata,
  output logic                            mem_req,
  output logic                            mem_we,
  output logic [WORD_SIZE-1:0]            mem_addr,
  output logic [WORD_SIZE*LINE_WORDS-1:0] mem_wdata,
  input  logic                            mem_ack,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] mem_rdata,
  output logic [15:0]                     i_grant_cnt,
  output logic [15:0]                     d_grant_cnt
);

  import mem_arbiter_pkg::*;

  state_t state;
  last_t  last_grant;
  logic   grant_i;
  logic   grant_d;

  // Grant decision, only meaningful in IDLE; ties go to whoever lost last time.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (i_req && d_req) begin
        grant_d = (last_grant == LAST_I);
        grant_i = (last_grant == LAST_D);
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  // Arbiter FSM with registered memory-port and ready outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= LAST_I;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state      <= GRANT_D;
            last_grant <= LAST_D;
            mem_req    <= 1'b1;
            mem_we     <= d_we;
            mem_addr   <= d_addr;
            mem_wdata  <= d_wdata;
          end else if (grant_i) begin
            state      <= GRANT_I;
            last_grant <= LAST_I;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= i_addr;
            mem_wdata  <= '0;
          end
        end
        GRANT_I: begin
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            i_ready <= 1'b1;
            i_rdata <= mem_rdata;
          end
        end
        GRANT_D: begin
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            d_ready <= 1'b1;
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  sat_counter16 u_i_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (grant_i),
    .count (i_grant_cnt)
  );

  sat_counter16 u_d_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (grant_d),
    .count (d_grant_cnt)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers feed request queues, a memory
// responder answers the port, monitors pop expected grants/completions.
module tb_mem_arbiter;

  localparam int unsigned WS = 16;
  localparam int unsigned LW = 64;

  typedef struct {
    logic          we;
    logic [WS-1:0] addr;
    logic [LW-1:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic          is_d;
    logic [LW-1:0] rdata;
  } rdy_exp_t;

  logic          clk;
  logic          reset;
  logic          i_req;
  logic [WS-1:0] i_addr;
  logic          i_ready;
  logic [LW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [WS-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic          d_ready;
  logic [LW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [WS-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic          mem_ack;
  logic [LW-1:0] mem_rdata;
  logic [15:0]   i_grant_cnt;
  logic [15:0]   d_grant_cnt;

  logic          sat_rst;
  logic          sat_en;
  logic [15:0]   sat_count;

  logic [WS-1:0] iq[$];
  mem_exp_t      dq[$];
  mem_exp_t      exp_mem[$];
  rdy_exp_t      exp_rdy[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int i_req_cyc = 0;
  int ack_cyc   = -10;
  int rise_cyc  = 0;
  int fall_cyc  = 0;
  int last_gap  = 0;
  int i_glitch_cyc  = -1;
  int d_abort_cyc   = -1;
  int force_ack_cyc = -1;
  int ack_delay = 0;
  logic resp_en = 1'b0;

  mem_arbiter #(
    .WORD_SIZE  (16),
    .LINE_WORDS (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_ready     (i_ready),
    .i_rdata     (i_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_ready     (d_ready),
    .d_rdata     (d_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .i_grant_cnt (i_grant_cnt),
    .d_grant_cnt (d_grant_cnt)
  );

  sat_counter16 u_sat (
    .clk   (clk),
    .reset (sat_rst),
    .en    (sat_en),
    .count (sat_count)
  );

  // Memory contents model: line returned for a given address.
  function automatic logic [LW-1:0] rd(input logic [WS-1:0] a);
    return {a, ~a, a ^ 16'h5A5A, a + 16'h0001};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, msg);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requester drivers: present queued requests, drop req on the ready edge.
  initial begin
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    forever begin
      mem_exp_t e;
      @(posedge clk); #1;
      if (i_req && i_ready) i_req = 1'b0;
      if (d_req && d_ready) d_req = 1'b0;
      if (cyc == i_glitch_cyc) begin
        i_addr = 16'h0BAD;
        i_req  = 1'b0;
      end
      if (cyc == d_abort_cyc) d_req = 1'b0;
      if (!i_req && iq.size() > 0) begin
        i_addr = iq.pop_front();
        i_req  = 1'b1;
        i_req_cyc = cyc;
      end
      if (!d_req && dq.size() > 0) begin
        e = dq.pop_front();
        d_we = e.we; d_addr = e.addr; d_wdata = e.wdata;
        d_req = 1'b1;
      end
    end
  end

  // Memory responder: ack ack_delay cycles after mem_req rises, plus forced acks.
  initial begin
    int rcnt;
    rcnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (cyc == force_ack_cyc) begin
        mem_ack = 1'b1;
      end else if (resp_en && mem_req) begin
        if (rcnt == ack_delay) begin
          mem_ack = 1'b1;
          mem_rdata = rd(mem_addr);
          ack_cyc = cyc;
          rcnt = 0;
        end else begin
          rcnt++;
        end
      end else begin
        rcnt = 0;
      end
    end
  end

  // Memory-port monitor: check each new access and that it is held stable.
  initial begin
    logic prev_req;
    mem_exp_t cur;
    mem_exp_t e;
    prev_req = 1'b0;
    cur = '{1'b0, '0, '0};
    forever begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        last_gap = cyc - fall_cyc;
        rise_cyc = cyc;
        if (exp_mem.size() == 0) begin
          fail_now("mem_unexpected", $sformatf("access addr %0h with none expected", mem_addr));
        end else begin
          e = exp_mem.pop_front();
          chk("mem_we", mem_we, e.we);
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_wdata", mem_wdata, e.wdata);
        end
        cur = '{mem_we, mem_addr, mem_wdata};
      end else if (mem_req) begin
        chk("mem_hold", {mem_we, mem_addr, mem_wdata}, {cur.we, cur.addr, cur.wdata});
      end
      if (!mem_req && prev_req) fall_cyc = cyc;
      prev_req = mem_req;
    end
  end

  // Completion monitor: every ready pulse must match the next expected one.
  initial begin
    rdy_exp_t e;
    forever begin
      @(negedge clk);
      if (i_ready || d_ready) begin
        chk("ready_one_hot", i_ready & d_ready, 1'b0);
        chk("ready_latency", cyc - ack_cyc, 1);
        if (exp_rdy.size() == 0) begin
          fail_now("ready_unexpected", $sformatf("i_ready=%b d_ready=%b with none expected", i_ready, d_ready));
        end else begin
          e = exp_rdy.pop_front();
          chk("ready_who", d_ready, e.is_d);
          if (e.is_d) chk("d_rdata", d_rdata, e.rdata);
          else        chk("i_rdata", i_rdata, e.rdata);
        end
      end
    end
  end

  task automatic wait_idle();
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (iq.size() == 0 && dq.size() == 0 && exp_mem.size() == 0 &&
          exp_rdy.size() == 0 && !i_req && !d_req && !mem_req) break;
    end
    if (k == 300) fail_now("wait_idle_timeout", "traffic did not drain within 300 cycles");
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_mem_req();
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    if (k == 50) fail_now("mem_req_timeout", "mem_req not seen within 50 cycles");
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    sat_rst = 1'b1;
    sat_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_mem_wdata", mem_wdata, 64'h0);
    chk("rst_i_ready", i_ready, 1'b0);
    chk("rst_d_ready", d_ready, 1'b0);
    chk("rst_i_rdata", i_rdata, 64'h0);
    chk("rst_d_rdata", d_rdata, 64'h0);
    chk("rst_i_cnt", i_grant_cnt, 16'h0);
    chk("rst_d_cnt", d_grant_cnt, 16'h0);

    // Single I fill, ack 3 cycles after mem_req
    ack_delay = 3;
    resp_en = 1'b1;
    exp_mem.push_back('{1'b0, 16'h0040, 64'h0});
    exp_rdy.push_back('{1'b0, 64'h0040_FFBF_5A1A_0041});
    iq.push_back(16'h0040);
    wait_idle();
    chk("req_latency", rise_cyc - i_req_cyc, 1);
    chk("t1_i_cnt", i_grant_cnt, 16'd1);
    chk("t1_d_cnt", d_grant_cnt, 16'd0);
    chk("t1_i_rdata_held", i_rdata, 64'h0040_FFBF_5A1A_0041);

    // Simultaneous I and D after reset: D (writeback) first, then I
    do_reset();
    ack_delay = 1;
    exp_mem.push_back('{1'b1, 16'h0100, 64'h1111_2222_3333_4444});
    exp_mem.push_back('{1'b0, 16'h0080, 64'h0});
    exp_rdy.push_back('{1'b1, 64'h0});
    exp_rdy.push_back('{1'b0, rd(16'h0080)});
    @(negedge clk);
    dq.push_back('{1'b1, 16'h0100, 64'h1111_2222_3333_4444});
    iq.push_back(16'h0080);
    wait_idle();
    chk("t2_gap", last_gap, 2);
    chk("t2_i_cnt", i_grant_cnt, 16'd1);
    chk("t2_d_cnt", d_grant_cnt, 16'd1);

    // Both held for six accesses: D,I,D,I,D,I
    do_reset();
    ack_delay = 0;
    exp_mem.push_back('{1'b0, 16'h0110, 64'hA0});
    exp_mem.push_back('{1'b0, 16'h0210, 64'h0});
    exp_mem.push_back('{1'b1, 16'h0120, 64'hA1});
    exp_mem.push_back('{1'b0, 16'h0220, 64'h0});
    exp_mem.push_back('{1'b0, 16'h0130, 64'hA2});
    exp_mem.push_back('{1'b0, 16'h0230, 64'h0});
    exp_rdy.push_back('{1'b1, rd(16'h0110)});
    exp_rdy.push_back('{1'b0, rd(16'h0210)});
    exp_rdy.push_back('{1'b1, rd(16'h0110)});
    exp_rdy.push_back('{1'b0, rd(16'h0220)});
    exp_rdy.push_back('{1'b1, rd(16'h0130)});
    exp_rdy.push_back('{1'b0, rd(16'h0230)});
    @(negedge clk);
    dq.push_back('{1'b0, 16'h0110, 64'hA0});
    dq.push_back('{1'b1, 16'h0120, 64'hA1});
    dq.push_back('{1'b0, 16'h0130, 64'hA2});
    iq.push_back(16'h0210);
    iq.push_back(16'h0220);
    iq.push_back(16'h0230);
    wait_idle();
    chk("t3_gap", last_gap, 2);
    chk("t3_i_cnt", i_grant_cnt, 16'd3);
    chk("t3_d_cnt", d_grant_cnt, 16'd3);

    // Reset during GRANT_D, late mem_ack must be ignored
    do_reset();
    resp_en = 1'b0;
    exp_mem.push_back('{1'b0, 16'h0200, 64'hBEEF});
    @(negedge clk);
    dq.push_back('{1'b0, 16'h0200, 64'hBEEF});
    wait_mem_req();
    chk("t4_d_cnt_granted", d_grant_cnt, 16'd1);
    d_abort_cyc = cyc + 1;
    force_ack_cyc = cyc + 3;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t4_mem_req", mem_req, 1'b0);
    chk("t4_d_cnt", d_grant_cnt, 16'd0);
    chk("t4_i_cnt", i_grant_cnt, 16'd0);
    repeat (4) @(negedge clk);
    chk("t4_mem_req_late", mem_req, 1'b0);
    chk("t4_d_rdata", d_rdata, 64'h0);

    // Spurious ack in IDLE, then I address changed and req dropped mid-grant
    resp_en = 1'b1;
    force_ack_cyc = cyc + 2;
    repeat (4) @(negedge clk);
    chk("t5_spurious_mem_req", mem_req, 1'b0);
    ack_delay = 4;
    exp_mem.push_back('{1'b0, 16'h0300, 64'h0});
    exp_rdy.push_back('{1'b0, rd(16'h0300)});
    iq.push_back(16'h0300);
    wait_mem_req();
    i_glitch_cyc = cyc + 1;
    repeat (2) @(negedge clk);
    chk("t5_mem_addr_latched", mem_addr, 16'h0300);
    chk("t5_mem_req_kept", mem_req, 1'b1);
    wait_idle();
    chk("t5_i_rdata", i_rdata, rd(16'h0300));
    chk("t5_i_cnt", i_grant_cnt, 16'd1);

    // Counter saturation: 65534 enables -> FFFE, 3 more -> FFFF
    @(posedge clk); #1 sat_rst = 1'b0; sat_en = 1'b1;
    repeat (65534) @(posedge clk);
    #1 chk("sat_fffe", sat_count, 16'hFFFE);
    repeat (3) @(posedge clk);
    #1 chk("sat_ffff", sat_count, 16'hFFFF);
    sat_en = 1'b0;
    sat_rst = 1'b1;
    @(posedge clk);
    #1 chk("sat_reset", sat_count, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
